// File: rtl/cdc_handshake_tx.sv
// Transmit side of a four-phase req/ack crossing: accepts a word over valid/ready,
// holds it on DataOut behind a level ReqOut, and retires it on a synchronized AckIn.
module cdc_handshake_tx #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             ReqOut,
    output logic [WIDTH-1:0] DataOut,
    input  logic             AckIn,
    output logic             Done,
    output logic             ProtoErr
);

    typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], AckIn};
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                // An ack seen while idle is a protocol violation; hold off accepts until it clears.
                if (ack_sync) begin
                    err_d = 1'b1;
                end else if (InValid) begin
                    data_d  = InData;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack_sync) begin
                    req_d   = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!ack_sync) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign InReady  = (state_q == StIdle) && !ack_sync;
    assign ReqOut   = req_q;
    assign DataOut  = data_q;
    assign Done     = done_q;
    assign ProtoErr = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: single/back-to-back transfers, data hold,
// spurious ack, async reset, and a randomized-phase ack loop with a scoreboard.
module tb_cdc_handshake_tx;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         InValid;
    logic [W-1:0] InData;
    logic         AckIn;
    logic         InReady;
    logic         ReqOut;
    logic [W-1:0] DataOut;
    logic         Done;
    logic         ProtoErr;

    int total = 0;
    int bad   = 0;
    int dones = 0;

    cdc_handshake_tx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .ReqOut   (ReqOut),
        .DataOut  (DataOut),
        .AckIn    (AckIn),
        .Done     (Done),
        .ProtoErr (ProtoErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full ack cycle from REQ: checks held data and the exact fall/Done edges.
    task automatic ack_cycle(input logic [W-1:0] held);
        AckIn = 1'b1;
        step();
        step();
        check("req_held_e2", ReqOut, 1'b1);
        check("data_held_req", DataOut, held);
        step();
        check("req_fall_e3", ReqOut, 1'b0);
        AckIn = 1'b0;
        step();
        step();
        check("done_not_yet", Done, 1'b0);
        check("data_held_release", DataOut, held);
        step();
        check("done_e3", Done, 1'b1);
        if (Done === 1'b1) dones++;
        check("ready_at_done", InReady, 1'b1);
    endtask

    task automatic wait_req_low(input int budget);
        for (int i = 0; i < budget && ReqOut !== 1'b0; i++) step();
        check("req_fall_timeout", ReqOut, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (Done === 1'b1) begin
                seen = 1'b1;
                dones++;
            end
        end
        check("done_timeout", seen, 1'b1);
    endtask

    initial begin
        logic [W-1:0] d;
        int           d0;

        reset   = 1'b1;
        InValid = 1'b0;
        InData  = '0;
        AckIn   = 1'b0;
        step();
        step();
        check("rst_req", ReqOut, 1'b0);
        check("rst_data", DataOut, 32'h0);
        check("rst_done", Done, 1'b0);
        check("rst_err", ProtoErr, 1'b0);
        check("rst_ready", InReady, 1'b1);
        reset = 1'b0;
        step();

        // Single transfer
        InData  = 32'hDEADBEEF;
        InValid = 1'b1;
        check("single_ready", InReady, 1'b1);
        step();
        InValid = 1'b0;
        check("single_req", ReqOut, 1'b1);
        check("single_data", DataOut, 32'hDEADBEEF);
        check("single_busy", InReady, 1'b0);
        step();
        step();
        ack_cycle(32'hDEADBEEF);
        step();
        check("done_one_cycle", Done, 1'b0);

        // Back-to-back: second accept lands in the Done cycle
        d0      = dones;
        InData  = 32'h1;
        InValid = 1'b1;
        step();
        check("b2b_first", DataOut, 32'h1);
        InData = 32'h2;
        ack_cycle(32'h1);
        step();
        check("b2b_second_req", ReqOut, 1'b1);
        check("b2b_second_data", DataOut, 32'h2);
        check("b2b_done_low", Done, 1'b0);
        InValid = 1'b0;
        ack_cycle(32'h2);
        repeat (4) step();
        check("b2b_no_dup", ReqOut, 1'b0);
        check("b2b_done_count", dones - d0, 2);

        // Data stability under toggling InData
        InData  = 32'hCAFE0001;
        InValid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            InData = $urandom;
            step();
            check("stable_data", DataOut, 32'hCAFE0001);
            check("stable_busy", InReady, 1'b0);
        end
        InValid = 1'b0;
        ack_cycle(32'hCAFE0001);
        step();

        // Spurious ack in idle
        AckIn = 1'b1;
        step();
        step();
        check("spur_ready", InReady, 1'b0);
        check("spur_err_pre", ProtoErr, 1'b0);
        InData  = 32'h55;
        InValid = 1'b1;
        step();
        check("spur_err_set", ProtoErr, 1'b1);
        check("spur_no_req", ReqOut, 1'b0);
        repeat (3) step();
        check("spur_no_req_hold", ReqOut, 1'b0);
        AckIn = 1'b0;
        step();
        check("spur_still_blocked", ReqOut, 1'b0);
        step();
        check("spur_ready_back", InReady, 1'b1);
        step();
        InValid = 1'b0;
        check("spur_resume_req", ReqOut, 1'b1);
        check("spur_resume_data", DataOut, 32'h55);
        ack_cycle(32'h55);
        check("spur_err_sticky", ProtoErr, 1'b1);
        step();

        // Asynchronous reset mid-transfer
        InData  = 32'hA5A5A5A5;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        check("mid_req", ReqOut, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("arst_req", ReqOut, 1'b0);
        check("arst_data", DataOut, 32'h0);
        check("arst_done", Done, 1'b0);
        check("arst_err", ProtoErr, 1'b0);
        step();
        reset = 1'b0;
        step();
        InData  = 32'h1234;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        check("post_rst_data", DataOut, 32'h1234);
        ack_cycle(32'h1234);
        step();

        // Randomized-phase acks with scoreboard
        d0 = dones;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 5 && InReady !== 1'b1; i++) step();
            d       = $urandom;
            InData  = d;
            InValid = 1'b1;
            step();
            InValid = 1'b0;
            InData  = $urandom;
            check("sb_data", DataOut, d);
            repeat ($urandom_range(0, 3)) step();
            #($urandom_range(0, 8));
            AckIn = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            wait_req_low(10);
            repeat ($urandom_range(0, 2)) step();
            #($urandom_range(0, 8));
            AckIn = 1'b0;
            wait_done(10);
        end
        check("rand_done_count", dones - d0, 1000);
        check("rand_no_err", ProtoErr, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
